mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline memory stage of the RV32I core, between execute and writeback.
- Consumes the execute-stage register (id_execute_stage_reg_t) and drives one data-memory request per load or store.
- Waits for the memory response and stalls upstream while it waits.
- Registers the result into the memory-stage register (id_memory_stage_reg_t) for writeback, including the data-memory fields that writeback commits.

Parameters:
- None. The data-memory interface is fixed at 32-bit address, 32-bit data and 4-bit byte masks.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ex_valid  in  1  ex_reg holds a live instruction this cycle.
- ex_reg  in  $bits(id_execute_stage_reg_t)  execute-stage register; upstream holds it stable while mem_stall=1.
- dmem_addr  out  32  word-aligned request address.
- dmem_rmask  out  4  read byte mask; nonzero only in the request cycle.
- dmem_wmask  out  4  write byte mask; nonzero only in the request cycle.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_rdata  in  32  read data; valid when dmem_resp=1.
- dmem_resp  in  1  one-cycle completion pulse.
- mem_stall  out  1  combinational; freezes fetch, decode and execute registers.
- mem_valid  out  1  mem_reg holds a live instruction.
- mem_reg  out  $bits(id_memory_stage_reg_t)  memory-stage register to writeback.
- stall_count  out  32  free-running count of cycles with mem_stall=1.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE; mem_valid=0; mem_reg all zeros; stall_count=0; dmem_rmask=0; dmem_wmask=0; dmem_addr=0; dmem_wdata=0.
- Memory op definition: ex_reg.opcode is op_b_load or op_b_store, and ex_valid=1.
- Effective address: ea = ex_reg.aluout.
- Request address: dmem_addr = {ea[31:2], 2'b00}.
- Masks by size, with o = ea[1:0]:
  - byte (lb/lbu/sb): 4'b0001 << o
  - half (lh/lhu/sh): 4'b0011 << o
  - word (lw/sw): 4'b1111
- Store data:
  - sb: rs2_v[7:0] replicated to all four lanes.
  - sh: rs2_v[15:0] replicated to both halves.
  - sw: rs2_v unchanged.
- Misaligned access: half with ea[0]=1, or word with ea[1:0]!=0.
  - No request is issued and both masks stay 0.
  - The instruction passes through in one cycle; a load writes rd_v=0.
  - No trap is raised.
- Load extraction from dmem_rdata at lane o:
  - lb/lh: sign-extended.
  - lbu/lhu: zero-extended.
  - lw: unchanged.
- FSM state IDLE:
  - Aligned memory op present: drive the masks, address and data combinationally this cycle, assert mem_stall, and move to WAIT.
  - Otherwise: mem_reg <= ex_reg fields, with rd_v = ex_reg.rd_v, dmem_rdata=0 and masks 0. mem_valid <= ex_valid.
- FSM state WAIT:
  - Masks are 0; the request fields are held in internal registers.
  - mem_stall = ~dmem_resp.
  - On dmem_resp: mem_reg <= ex fields plus the recorded addr, rmask, wmask, wdata and dmem_rdata. rd_v gets the extracted load data; for stores rd_v is 0. mem_valid <= 1. Return to IDLE.
  - Stall deasserts in the response cycle, so the next instruction is sampled at the following edge.
- mem_valid while stalled: 0 in every cycle from the request edge up to the response edge (a bubble goes to writeback).
- Response timing: dmem_resp is guaranteed no earlier than the cycle after the request. A dmem_resp seen in IDLE is ignored.
- Reset while in WAIT: return to IDLE and drop the pending access. A late dmem_resp after reset is ignored by the IDLE rule.
- commit: mem_reg.commit = ex_reg.commit & ex_valid. The order field passes through unchanged.
- stall_count: increments by 1 in every cycle with mem_stall=1; wraps modulo 2^32.

Decomposition:
- Shared package (rv32i_types) gains:
  - mem_fsm_state_t {IDLE, WAIT}
  - mem_size_t {byte, half, word}
- One combinational sub-module, mem_align:
  - inputs: funct3, ea[1:0], rs2_v, raw rdata
  - outputs: rmask, wmask, wdata, extracted load value, misaligned flag
- mem_stage holds the FSM, the request-hold registers, the output register and the counter.

Test Plan:
- lw, ea=0x1000, dmem_resp two cycles later with rdata=0xDEADBEEF -> rmask=4'b1111 for one cycle; mem_stall high for 2 cycles; mem_reg.rd_v=0xDEADBEEF; mem_valid=1 exactly once; stall_count=2.
- lb, ea=0x1003, rdata=0x80FF_FF00 -> rmask=4'b1000; rd_v=0xFFFFFF80. Repeat as lbu -> rd_v=0x00000080.
- sh, ea=0x2002, rs2_v=0x1234ABCD -> dmem_addr=0x2000; wmask=4'b1100; wdata=0xABCDABCD; after resp, mem_reg.rd_v=0.
- lw, ea=0x1001 (misaligned) -> masks stay 0; no stall; mem_reg.rd_v=0 next cycle.
- Back-to-back: add, then sw with resp after 3 cycles, then add -> add results are not lost; upstream frozen during the stall; commit/order sequence contiguous at mem_reg.
- rst asserted in WAIT, then dmem_resp one cycle after rst deasserts -> mem_valid stays 0; state IDLE; stall_count=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rv32i_types: shared opcodes, pipeline-register structs and memory-stage enums.
package rv32i_types;

    localparam logic [6:0] op_b_load  = 7'b0000011;
    localparam logic [6:0] op_b_store = 7'b0100011;
    localparam logic [6:0] op_b_reg   = 7'b0110011;

    typedef enum logic {IDLE, WAIT} mem_fsm_state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_t;

    typedef struct packed {
        logic [63:0] order;
        logic        commit;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic [31:0] rs2_v;
        logic [31:0] aluout;
    } id_execute_stage_reg_t;

    typedef struct packed {
        logic [63:0] order;
        logic        commit;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic [31:0] dmem_addr;
        logic [3:0]  dmem_rmask;
        logic [3:0]  dmem_wmask;
        logic [31:0] dmem_wdata;
        logic [31:0] dmem_rdata;
    } id_memory_stage_reg_t;

    function automatic mem_size_t size_of(input logic [2:0] funct3);
        return funct3[1] ? SZ_WORD : (funct3[0] ? SZ_HALF : SZ_BYTE);
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: byte-lane masks, store-data replication and load extraction for one access.
module mem_align
    import rv32i_types::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rs2_v,
    input  logic [31:0] rdata,
    output logic [3:0]  rmask,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] load_v,
    output logic        misaligned
);
    mem_size_t   size;
    logic [3:0]  mask;
    logic [31:0] lane;

    always_comb begin
        size       = size_of(funct3);
        misaligned = (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
        mask       = (size == SZ_WORD) ? 4'b1111 : ((size == SZ_HALF ? 4'b0011 : 4'b0001) << off);
        rmask      = (is_load && !misaligned) ? mask : 4'b0000;
        wmask      = (is_store && !misaligned) ? mask : 4'b0000;
        wdata      = (size == SZ_BYTE) ? {4{rs2_v[7:0]}} : ((size == SZ_HALF) ? {2{rs2_v[15:0]}} : rs2_v);
        lane       = rdata >> {off, 3'b000};
        // funct3[2] marks the unsigned variants (lbu/lhu)
        load_v     = (size == SZ_WORD) ? rdata :
                     (size == SZ_HALF) ? {{16{lane[15] & ~funct3[2]}}, lane[15:0]} :
                                         {{24{lane[7] & ~funct3[2]}}, lane[7:0]};
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage; issues one data-memory request per aligned load/store,
// stalls upstream until the response, and registers the result for writeback.
module mem_stage
    import rv32i_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  id_execute_stage_reg_t ex_reg,
    output logic [31:0]           dmem_addr,
    output logic [3:0]            dmem_rmask,
    output logic [3:0]            dmem_wmask,
    output logic [31:0]           dmem_wdata,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_resp,
    output logic                  mem_stall,
    output logic                  mem_valid,
    output id_memory_stage_reg_t  mem_reg,
    output logic [31:0]           stall_count
);
    mem_fsm_state_t       state_q, state_d;
    logic [31:0]          addr_q, addr_d, wdata_q, wdata_d, cnt_q, cnt_d;
    logic [3:0]           rmask_q, rmask_d, wmask_q, wmask_d;
    logic                 valid_q, valid_d;
    id_memory_stage_reg_t reg_q, reg_d, pass;
    logic                 is_load, is_store, is_mem, issue, done, mis;
    logic [3:0]           a_rmask, a_wmask;
    logic [31:0]          a_wdata, load_v, req_addr;

    assign is_load  = ex_valid && ex_reg.opcode == op_b_load;
    assign is_store = ex_valid && ex_reg.opcode == op_b_store;

    mem_align u_align (
        .is_load   (is_load),
        .is_store  (is_store),
        .funct3    (ex_reg.funct3),
        .off       (ex_reg.aluout[1:0]),
        .rs2_v     (ex_reg.rs2_v),
        .rdata     (dmem_rdata),
        .rmask     (a_rmask),
        .wmask     (a_wmask),
        .wdata     (a_wdata),
        .load_v    (load_v),
        .misaligned(mis)
    );

    always_comb begin
        is_mem     = is_load || is_store;
        issue      = !rst && state_q == IDLE && is_mem && !mis;
        done       = state_q == WAIT && dmem_resp;
        req_addr   = {ex_reg.aluout[31:2], 2'b00};
        mem_stall  = issue || (state_q == WAIT && !dmem_resp);
        dmem_rmask = issue ? a_rmask : 4'b0000;
        dmem_wmask = issue ? a_wmask : 4'b0000;
        dmem_addr  = issue ? req_addr : (state_q == WAIT ? addr_q : 32'b0);
        dmem_wdata = issue ? a_wdata : (state_q == WAIT ? wdata_q : 32'b0);
        state_d    = issue ? WAIT : (done ? IDLE : state_q);
        addr_d     = issue ? req_addr : addr_q;
        rmask_d    = issue ? a_rmask : rmask_q;
        wmask_d    = issue ? a_wmask : wmask_q;
        wdata_d    = issue ? a_wdata : wdata_q;
        cnt_d      = cnt_q + 32'(mem_stall);
        pass            = '0;
        pass.order      = ex_reg.order;
        pass.commit     = ex_reg.commit && ex_valid;
        pass.pc         = ex_reg.pc;
        pass.opcode     = ex_reg.opcode;
        pass.funct3     = ex_reg.funct3;
        pass.rd_s       = ex_reg.rd_s;
        // a memory op that completes from IDLE is misaligned and writes zero
        pass.rd_v       = done ? (is_load ? load_v : 32'b0) : (is_mem ? 32'b0 : ex_reg.rd_v);
        pass.dmem_addr  = done ? addr_q : 32'b0;
        pass.dmem_rmask = done ? rmask_q : 4'b0000;
        pass.dmem_wmask = done ? wmask_q : 4'b0000;
        pass.dmem_wdata = done ? wdata_q : 32'b0;
        pass.dmem_rdata = done ? dmem_rdata : 32'b0;
        reg_d      = ((state_q == IDLE && !issue) || done) ? pass : reg_q;
        valid_d    = (state_q == IDLE) ? (ex_valid && !issue) : done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rmask_q <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            reg_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rmask_q <= rmask_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            reg_q   <= reg_d;
        end
    end

    assign mem_valid   = valid_q;
    assign mem_reg     = reg_q;
    assign stall_count = cnt_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus hand sequences for back-to-back and reset-in-wait.
module tb_mem_stage;
    import rv32i_types::*;

    logic                  clk = 1'b0;
    logic                  rst, ex_valid, dmem_resp, mem_stall, mem_valid;
    id_execute_stage_reg_t ex_reg;
    logic [31:0]           dmem_addr, dmem_wdata, dmem_rdata, stall_count;
    logic [3:0]            dmem_rmask, dmem_wmask;
    id_memory_stage_reg_t  mem_reg;

    int errors = 0;
    int checks = 0;
    logic [63:0] ord = 64'd100;

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_reg     (ex_reg),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_stall  (mem_stall),
        .mem_valid  (mem_valid),
        .mem_reg    (mem_reg),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] ea, rs2, rdin, rdata;
        int          delay;
        logic [3:0]  rm, wm;
        logic [31:0] addr, wdata, rd;
    } vec_t;

    vec_t v[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] ea,
                         input logic [31:0] rs2, input logic [31:0] rdin);
        ex_valid      = 1'b1;
        ex_reg        = '0;
        ex_reg.order  = ord;
        ex_reg.commit = 1'b1;
        ex_reg.pc     = 32'h8000_0000 + ord[31:0] * 4;
        ex_reg.opcode = op;
        ex_reg.funct3 = f3;
        ex_reg.rd_s   = 5'd3;
        ex_reg.rd_v   = rdin;
        ex_reg.rs2_v  = rs2;
        ex_reg.aluout = ea;
    endtask

    // entered and left #1 after a rising edge
    task automatic run_vec(input vec_t t);
        logic [31:0] c0;
        logic        req;
        req = (t.rm | t.wm) != 4'b0000;
        c0  = stall_count;
        drive(t.op, t.f3, t.ea, t.rs2, t.rdin);
        #1;
        chk({t.name, ".rmask"}, 32'(dmem_rmask), 32'(t.rm));
        chk({t.name, ".wmask"}, 32'(dmem_wmask), 32'(t.wm));
        chk({t.name, ".addr"}, dmem_addr, t.addr);
        chk({t.name, ".wdata"}, dmem_wdata, t.wdata);
        chk({t.name, ".stall"}, 32'(mem_stall), 32'(req));
        @(posedge clk); #1;
        if (req) begin
            for (int c = 1; c <= t.delay; c++) begin
                dmem_resp  = (c == t.delay);
                dmem_rdata = t.rdata;
                #1;
                chk({t.name, ".wait_masks"}, 32'({dmem_rmask, dmem_wmask}), 32'd0);
                chk({t.name, ".wait_valid"}, 32'(mem_valid), 32'd0);
                chk({t.name, ".wait_stall"}, 32'(mem_stall), 32'(c != t.delay));
                @(posedge clk); #1;
                dmem_resp = 1'b0;
            end
        end
        ex_valid = 1'b0;
        chk({t.name, ".valid"}, 32'(mem_valid), 32'd1);
        chk({t.name, ".rd_v"}, mem_reg.rd_v, t.rd);
        chk({t.name, ".order"}, mem_reg.order[31:0], ord[31:0]);
        chk({t.name, ".commit"}, 32'(mem_reg.commit), 32'd1);
        chk({t.name, ".reg_rmask"}, 32'(mem_reg.dmem_rmask), 32'(t.rm));
        chk({t.name, ".reg_wmask"}, 32'(mem_reg.dmem_wmask), 32'(t.wm));
        chk({t.name, ".reg_addr"}, mem_reg.dmem_addr, req ? t.addr : 32'd0);
        chk({t.name, ".reg_rdata"}, mem_reg.dmem_rdata, req ? t.rdata : 32'd0);
        chk({t.name, ".stall_count"}, stall_count - c0, 32'(t.delay));
        @(posedge clk); #1;
        chk({t.name, ".valid_once"}, 32'(mem_valid), 32'd0);
        ord++;
    endtask

    initial begin
        logic [63:0] base;
        logic [63:0] got[$];
        logic        gotc[$];
        int          since, idx;
        logic        adv;
        id_execute_stage_reg_t prog[3];

        //          name     op          f3      ea            rs2           rdin          rdata         dly rm       wm       addr          wdata         rd
        v[0]  = '{"lw",    op_b_load,  3'b010, 32'h0000_1000, 32'h0,        32'h0,        32'hDEAD_BEEF, 2, 4'b1111, 4'b0000, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF};
        v[1]  = '{"lb",    op_b_load,  3'b000, 32'h0000_1003, 32'h0,        32'h0,        32'h80FF_FF00, 1, 4'b1000, 4'b0000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80};
        v[2]  = '{"lbu",   op_b_load,  3'b100, 32'h0000_1003, 32'h0,        32'h0,        32'h80FF_FF00, 1, 4'b1000, 4'b0000, 32'h0000_1000, 32'h0,        32'h0000_0080};
        v[3]  = '{"sh",    op_b_store, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h11,      32'h0,         1, 4'b0000, 4'b1100, 32'h0000_2000, 32'hABCD_ABCD, 32'h0};
        v[4]  = '{"lw_mis",op_b_load,  3'b010, 32'h0000_1001, 32'h0,        32'h99,       32'h0,         0, 4'b0000, 4'b0000, 32'h0,         32'h0,        32'h0};
        v[5]  = '{"lh",    op_b_load,  3'b001, 32'h0000_1002, 32'h0,        32'h0,        32'h8001_0000, 2, 4'b1100, 4'b0000, 32'h0000_1000, 32'h0,        32'hFFFF_8001};
        v[6]  = '{"lhu",   op_b_load,  3'b101, 32'h0000_1000, 32'h0,        32'h0,        32'h1234_F00D, 1, 4'b0011, 4'b0000, 32'h0000_1000, 32'h0,        32'h0000_F00D};
        v[7]  = '{"sw",    op_b_store, 3'b010, 32'h0000_3000, 32'hCAFE_BABE, 32'h0,       32'h0,         3, 4'b0000, 4'b1111, 32'h0000_3000, 32'hCAFE_BABE, 32'h0};
        v[8]  = '{"sb",    op_b_store, 3'b000, 32'h0000_4001, 32'h0000_00A5, 32'h0,       32'h0,         1, 4'b0000, 4'b0010, 32'h0000_4000, 32'hA5A5_A5A5, 32'h0};
        v[9]  = '{"add",   op_b_reg,   3'b000, 32'h0000_5003, 32'h0,        32'h55,       32'h0,         0, 4'b0000, 4'b0000, 32'h0,         32'h0,        32'h55};
        v[10] = '{"sh_mis",op_b_store, 3'b001, 32'h0000_2001, 32'h1234_ABCD, 32'h0,       32'h0,         0, 4'b0000, 4'b0000, 32'h0,         32'h0,        32'h0};

        rst = 1'b1; ex_valid = 1'b0; ex_reg = '0; dmem_resp = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst.mem_valid", 32'(mem_valid), 32'd0);
        chk("rst.mem_reg_zero", 32'(mem_reg == '0), 32'd1);
        chk("rst.stall_count", stall_count, 32'd0);
        chk("rst.masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
        chk("rst.addr", dmem_addr, 32'd0);
        chk("rst.wdata", dmem_wdata, 32'd0);
        chk("rst.stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_vec(v[i]);

        // back-to-back: add, sw answered 3 cycles after request, add
        base = ord;
        drive(op_b_reg, 3'b000, 32'h0, 32'h0, 32'h1); prog[0] = ex_reg; ord++;
        drive(op_b_store, 3'b010, 32'h0000_3004, 32'h7777_8888, 32'h0); prog[1] = ex_reg; ord++;
        drive(op_b_reg, 3'b000, 32'h0, 32'h0, 32'h2); prog[2] = ex_reg; ord++;
        ex_valid = 1'b0;
        since = 0; idx = 0;
        repeat (12) begin
            if (mem_valid) begin
                got.push_back(mem_reg.order);
                gotc.push_back(mem_reg.commit);
            end
            ex_valid  = idx < 3;
            ex_reg    = prog[idx < 3 ? idx : 2];
            dmem_resp = since == 3;
            #1;
            if (dmem_wmask != 4'b0000) since = 1;
            else if (since > 0 && since < 3) since++;
            else since = 0;
            adv = !mem_stall;
            @(posedge clk); #1;
            dmem_resp = 1'b0;
            if (adv && idx < 3) idx++;
        end
        ex_valid = 1'b0;
        chk("b2b.count", 32'(got.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk("b2b.order", (k < got.size()) ? got[k][31:0] : 32'hFFFF_FFFF, base[31:0] + 32'(k));
            chk("b2b.commit", (k < gotc.size()) ? 32'(gotc[k]) : 32'hFFFF_FFFF, 32'd1);
        end

        // reset while waiting for a response, then a late response
        drive(op_b_load, 3'b010, 32'h0000_1000, 32'h0, 32'h0);
        #1 chk("rstw.stall", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; ex_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstw.valid0", 32'(mem_valid), 32'd0);
        chk("rstw.count0", stall_count, 32'd0);
        @(posedge clk); #1;
        dmem_resp = 1'b1; dmem_rdata = 32'h1111_2222;
        #1;
        chk("rstw.late_stall", 32'(mem_stall), 32'd0);
        chk("rstw.late_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        chk("rstw.valid1", 32'(mem_valid), 32'd0);
        chk("rstw.count1", stall_count, 32'd0);
        @(posedge clk); #1;
        chk("rstw.valid2", 32'(mem_valid), 32'd0);
        run_vec(v[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
